// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the sync meter FSM state encoding.
package vga_pkg;

    // Default 640x480@60 timing, identical to the generator's defaults.
    localparam int H_VIEW  = 640;
    localparam int H_FRONT = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VIEW  = 480;
    localparam int V_FRONT = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;

    // Lock acquisition states of the sync meter.
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_VERIFY  = 2'd2,
        ST_LOCKED  = 2'd3
    } meter_state_e;

endpackage

// File: rtl/vga_sync_meter_if.sv
// Video sync input and measurement bundle of the sync meter.
// There is no handshake: the sync lines are free-running levels and every
// measurement output is a level that is valid on every clock (frame_start is
// a single-cycle strobe).
interface vga_sync_meter_if #(
    parameter int H_CNT_W = 11,
    parameter int V_CNT_W = 10
);
    logic               hsync_in;
    logic               vsync_in;
    logic [H_CNT_W-1:0] h_total;
    logic [H_CNT_W-1:0] h_sync_w;
    logic [V_CNT_W-1:0] v_total;
    logic [V_CNT_W-1:0] v_sync_w;
    logic [H_CNT_W-1:0] line_pos;
    logic [V_CNT_W-1:0] line_num;
    logic               frame_start;
    logic               locked;
    logic               timeout;

    // Video source / observer side.
    modport master (
        output hsync_in, vsync_in,
        input  h_total, h_sync_w, v_total, v_sync_w,
        input  line_pos, line_num, frame_start, locked, timeout
    );

    // Meter side.
    modport slave (
        input  hsync_in, vsync_in,
        output h_total, h_sync_w, v_total, v_sync_w,
        output line_pos, line_num, frame_start, locked, timeout
    );
endinterface

// File: rtl/vga_sync_meter_sync_edge_detect.sv
// Polarity normalisation, synchronizer, and rise/fall strobes for one sync input.
module sync_edge_detect #(
    parameter bit POL    = 1'b1,
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);
    logic              active;
    logic [STAGES-1:0] sync_q;
    logic              dly_q;
    logic              s;

    // 1 means "sync active" regardless of the source polarity.
    assign active = sig_i ^ ~POL;
    assign s      = sync_q[STAGES-1];

    // Synchronizer chain followed by one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q[0] <= active;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= s;
        end
    end

    assign rise_o = s & ~dly_q;
    assign fall_o = ~s & dly_q;
endmodule

// File: rtl/vga_sync_meter.sv
// Receive-side VGA sync meter: measures line/frame timing, tracks position
// within the frame and declares lock once the timing is stable.
module vga_sync_meter
    import vga_pkg::*;
#(
    parameter int H_CNT_W     = 11,
    parameter int V_CNT_W     = 10,
    parameter bit HSYNC_POL   = 1'b1,
    parameter bit VSYNC_POL   = 1'b1,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_LINES  = 16
) (
    input  logic            clk,
    input  logic            reset,
    vga_sync_meter_if.slave vid,
    output meter_state_e    dbg_state_o
);
    localparam int                 HM_W   = $clog2(LOCK_LINES + 1);
    localparam logic [H_CNT_W-1:0] H_MAX  = '1;
    localparam logic [V_CNT_W-1:0] V_MAX  = '1;
    localparam logic [HM_W-1:0]    HM_MAX = HM_W'(LOCK_LINES);

    logic h_rise, h_fall, v_rise, v_fall;

    sync_edge_detect #(.POL(HSYNC_POL), .STAGES(SYNC_STAGES)) u_h_edge (
        .clk(clk), .reset(reset), .sig_i(vid.hsync_in), .rise_o(h_rise), .fall_o(h_fall)
    );
    sync_edge_detect #(.POL(VSYNC_POL), .STAGES(SYNC_STAGES)) u_v_edge (
        .clk(clk), .reset(reset), .sig_i(vid.vsync_in), .rise_o(v_rise), .fall_o(v_fall)
    );

    logic [H_CNT_W-1:0] hcnt_q, hcnt_d, h_total_q, h_total_d, h_sync_w_q, h_sync_w_d;
    logic [V_CNT_W-1:0] vcnt_q, vcnt_d, v_total_q, v_total_d, v_sync_w_q, v_sync_w_d;
    logic [HM_W-1:0]    hm_q, hm_d;
    logic               timeout_q, timeout_d, frame_start_q;
    meter_state_e       state_q, state_d;

    logic h_sat, v_sat, any_sat, h_match, v_match, hm_ok;

    // A counter is saturated when it sits at full scale and would otherwise advance.
    assign h_sat   = !h_rise && (hcnt_q == H_MAX);
    assign v_sat   = h_rise && !v_rise && (vcnt_q == V_MAX);
    assign any_sat = h_sat | v_sat;
    assign h_match = (hcnt_q == h_total_q);
    assign v_match = (vcnt_q == v_total_q);
    assign hm_ok   = (hm_q == HM_MAX);

    // Measurement counters, latches and the equal-line run counter.
    always_comb begin
        hcnt_d     = hcnt_q;
        h_total_d  = h_total_q;
        h_sync_w_d = h_sync_w_q;
        vcnt_d     = vcnt_q;
        v_total_d  = v_total_q;
        v_sync_w_d = v_sync_w_q;
        hm_d       = hm_q;
        timeout_d  = timeout_q | any_sat;

        if (h_rise) begin
            h_total_d = hcnt_q;
            hcnt_d    = H_CNT_W'(1);
        end else if (!h_sat) begin
            hcnt_d = hcnt_q + 1'b1;
        end
        if (h_fall) h_sync_w_d = hcnt_q;

        // A coincident h_rise already belongs to the new frame, hence vcnt = 1.
        if (v_rise) begin
            v_total_d = vcnt_q;
            vcnt_d    = h_rise ? V_CNT_W'(1) : '0;
        end else if (h_rise && !v_sat) begin
            vcnt_d = vcnt_q + 1'b1;
        end
        if (v_fall) v_sync_w_d = vcnt_q;

        // Compared against the previous line length, so the first line never counts.
        if (h_rise) begin
            if (!h_match)   hm_d = '0;
            else if (!hm_ok) hm_d = hm_q + 1'b1;
        end
    end

    // Lock FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH:  if (v_rise) state_d = ST_MEASURE;
            ST_MEASURE: begin
                if (any_sat)     state_d = ST_SEARCH;
                else if (v_rise) state_d = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (any_sat)                          state_d = ST_SEARCH;
                else if (v_rise && v_match && hm_ok)  state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (any_sat || (h_rise && !h_match) || (v_rise && !v_match))
                    state_d = ST_SEARCH;
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // State and measurement registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_SEARCH;
            hcnt_q        <= '0;
            h_total_q     <= '0;
            h_sync_w_q    <= '0;
            vcnt_q        <= '0;
            v_total_q     <= '0;
            v_sync_w_q    <= '0;
            hm_q          <= '0;
            timeout_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            h_total_q     <= h_total_d;
            h_sync_w_q    <= h_sync_w_d;
            vcnt_q        <= vcnt_d;
            v_total_q     <= v_total_d;
            v_sync_w_q    <= v_sync_w_d;
            hm_q          <= hm_d;
            timeout_q     <= timeout_d;
            frame_start_q <= v_rise;
        end
    end

    // Output decode.
    always_comb begin
        vid.h_total     = h_total_q;
        vid.h_sync_w    = h_sync_w_q;
        vid.v_total     = v_total_q;
        vid.v_sync_w    = v_sync_w_q;
        vid.line_pos    = hcnt_q;
        vid.line_num    = vcnt_q;
        vid.frame_start = frame_start_q;
        vid.locked      = (state_q == ST_LOCKED);
        vid.timeout     = timeout_q;
        dbg_state_o     = state_q;
    end
endmodule
